// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/done/kill handshake.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module muldiv_unit #(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next;
  logic [XLEN:0]       div_shl;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, fix_val;

  // Operand decode at acceptance
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    neg_a    = a_signed && a[XLEN-1];
    neg_b    = b_signed && b[XLEN-1];
    abs_a    = neg_a ? -a : a;
    abs_b    = neg_b ? -b : b;
  end

  // Multiply step: multiplier sits in the low half and shifts out LSB first
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Divide step: remainder in the high half, dividend shifts into it MSB first
  // while quotient bits fill the vacated low positions.
  always_comb begin
    div_shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_shl >= {1'b0, mb_q};
    div_rem  = div_ge ? XLEN'(div_shl - {1'b0, mb_q}) : div_shl[XLEN-1:0];
    div_next = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                fix_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_val = quo_s;
      default:               fix_val = rem_s;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  always_comb begin
    fast_a = a_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    fast_b = b_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    fast_p = fast_a * fast_b;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          sa_d  = neg_a;
          sb_d  = neg_b;
          ma_d  = abs_a;
          mb_d  = abs_b;
          cnt_d = '0;
          if (funct3[2]) begin
            acc_d = {{XLEN{1'b0}}, abs_a};
            if (b == '0) begin
              result_d = funct3[1] ? a : '1;
              state_d  = S_DONE;
            end else if (b_signed && a == MIN_NEG && b == '1) begin
              result_d = funct3[1] ? '0 : a;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = (funct3 == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`else
            acc_d    = {{XLEN{1'b0}}, abs_b};
            state_d  = S_CALC;
`endif
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = op_q[2] ? div_next : mul_next;
          if (cnt_d == CNT_W'(XLEN)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32); latency counted in cycles after the accepting edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a start at edge 0, scramble the inputs, then count cycles until done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] expv);
    int cyc;
    @(negedge clk);
    start = 1'b1; funct3 = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (done) begin cyc = i; break; end
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(lat));
    chk({tag, ".res"}, result, expv);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int seen;
    #2;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.res", result, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("mulh",   3'b001, 32'hFFFFFFFE, 32'h00000003, MUL_LAT, 32'hFFFFFFFF);
    run_op("mul",    3'b000, 32'hFFFFFFFE, 32'h00000003, MUL_LAT, 32'hFFFFFFFA);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFF);
    run_op("mulh2",  3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, MUL_LAT, 32'h3FFFFFFF);
    run_op("mul67",  3'b000, 32'd6,        32'd7,        MUL_LAT, 32'd42);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFD);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF);
    run_op("div2",   3'b100, 32'd7,        32'hFFFFFFFE, DIV_LAT, 32'hFFFFFFFD);
    run_op("rem2",   3'b110, 32'd7,        32'hFFFFFFFE, DIV_LAT, 32'd1);
    run_op("divu",   3'b101, 32'd100,      32'd7,        DIV_LAT, 32'd14);
    run_op("remu",   3'b111, 32'd100,      32'd7,        DIV_LAT, 32'd2);
    run_op("divu0",  3'b101, 32'h1234,     32'd0,        1,       32'hFFFFFFFF);
    run_op("remu0",  3'b111, 32'h1234,     32'd0,        1,       32'h1234);
    run_op("div0",   3'b100, 32'hFFFFFFFB, 32'd0,        1,       32'hFFFFFFFF);
    run_op("rem0",   3'b110, 32'hFFFFFFFB, 32'd0,        1,       32'hFFFFFFFB);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1,       32'h80000000);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1,       32'd0);
    // Unsigned divide of the same bit pattern is not a special case
    run_op("divuovf", 3'b101, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'd0);

    // kill together with start in IDLE: start wins
    @(negedge clk); kill = 1'b1;
    run_op("killstart", 3'b101, 32'd100, 32'd10, DIV_LAT, 32'd10);

    // kill in cycle 10 of an iterative op (DIVU so it is iterative in both builds)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd50; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    chk("kill.busy10", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill.busy11", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    chk("kill.nodone", 32'(seen), 32'd0);
    chk("kill.res", result, 32'd10);

    // start re-pulsed while busy and held through DONE: one done, original operands
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd90; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    start = 1'b1; funct3 = 3'b111; a = 32'd5; b = 32'd0;
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !done; i++) begin @(posedge clk); #1; end
    if (done) seen++;
    start = 1'b1;
    chk("rep.res", result, 32'd10);
    @(posedge clk); #1;
    chk("rep.idle", {31'b0, busy}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    chk("rep.onedone", 32'(seen), 32'd1);

    // asynchronous reset in cycle 5 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst.busy", {31'b0, busy}, 32'd0);
    chk("arst.done", {31'b0, done}, 32'd0);
    chk("arst.res", result, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("post", 3'b100, 32'd1000, 32'd7, DIV_LAT, 32'd142);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
